// File: rtl/neuron_lut_loader.sv
// Runtime-loadable truth table for one neuron: unpacks a checksummed byte stream
// into NW rows of DATA_W bits, then serves registered lookups M0 -> M1.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | no load in progress; stream words are ignored
//   ST_LOAD  | accepting table words 0..NW-1 into RAM rows
//   ST_CHECK | waiting for the XOR checksum word
module neuron_lut_loader #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 2,
   parameter int DATA_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic [DATA_W-1:0]   s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                cfg_busy,
   output logic                cfg_done,
   output logic                cfg_err,
   output logic                tbl_valid,
   input  logic                in_valid,
   input  logic [IN_BITS-1:0]  M0,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] M1
);

   localparam int EPW    = DATA_W / OUT_BITS;
   localparam int NW     = (1 << IN_BITS) / EPW;
   localparam int LANE_W = $clog2(EPW);
   localparam int ROW_W  = IN_BITS - LANE_W;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NW - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   logic [1:0]          state;
   logic [ROW_W-1:0]    cnt;
   logic [DATA_W-1:0]   csum;
   logic [DATA_W-1:0]   mem [NW];
   logic                accept;
   logic [ROW_W-1:0]    row;
   logic [LANE_W-1:0]   lane;
   logic [DATA_W-1:0]   row_word;
   logic [OUT_BITS-1:0] lanes [EPW];

   assign s_ready  = (state == ST_LOAD) || (state == ST_CHECK);
   assign cfg_busy = s_ready;
   // a word coinciding with cfg_start belongs to the aborted load, so drop it
   assign accept   = s_valid && s_ready && !cfg_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         csum      <= '0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         tbl_valid <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         if (cfg_start) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            csum      <= '0;
            cfg_err   <= 1'b0;
            tbl_valid <= 1'b0;
         end else if (accept) begin
            case (state)
               ST_LOAD: begin
                  csum <= csum ^ s_data;
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST_ROW) state <= ST_CHECK;
               end
               ST_CHECK: begin
                  if (s_data == csum) begin
                     tbl_valid <= 1'b1;
                     cfg_done  <= 1'b1;
                  end else begin
                     cfg_err <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // table storage is deliberately unreset so it maps to distributed RAM
   always_ff @(posedge clk) begin
      if (accept && (state == ST_LOAD)) mem[cnt] <= s_data;
   end

   assign row      = M0[IN_BITS-1:LANE_W];
   assign lane     = M0[LANE_W-1:0];
   assign row_word = mem[row];

   always_comb begin
      for (int j = 0; j < EPW; j++) lanes[j] = row_word[j*OUT_BITS +: OUT_BITS];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         M1        <= '0;
      end else begin
         out_valid <= in_valid && tbl_valid;
         if (in_valid && tbl_valid) M1 <= lanes[lane];
      end
   end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Directed-plus-random bench for neuron_lut_loader against a flat 64-entry
// table model rebuilt from the committed word list.
module tb_neuron_lut_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_start;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       cfg_busy;
   logic       cfg_done;
   logic       cfg_err;
   logic       tbl_valid;
   logic       in_valid;
   logic [5:0] M0;
   logic       out_valid;
   logic [1:0] M1;

   int checks = 0;
   int errors = 0;

   logic [1:0] model_tbl [64];
   logic [7:0] pend [16];
   logic [7:0] words [16];
   logic [7:0] sum;
   int         n;
   bit         model_valid, model_busy, model_err;
   logic [1:0] model_m1;

   always #5 clk = ~clk;

   neuron_lut_loader dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .cfg_err(cfg_err), .tbl_valid(tbl_valid),
      .in_valid(in_valid), .M0(M0), .out_valid(out_valid), .M1(M1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic commit();
      for (int i = 0; i < 64; i++) model_tbl[i] = 2'((pend[i/4] >> (2*(i%4))) & 8'h03);
      model_valid = 1;
   endtask

   task automatic start(input bit with_valid);
      @(negedge clk);
      cfg_start = 1; s_valid = with_valid; s_data = 8'hA5;
      @(negedge clk);
      cfg_start = 0; s_valid = 0;
      model_busy = 1; model_valid = 0; model_err = 0; n = 0; sum = 8'h00;
      chk("busy_after_start", cfg_busy, 1);
      chk("tbl_valid_after_start", tbl_valid, 0);
      chk("err_after_start", cfg_err, 0);
   endtask

   task automatic send(input logic [7:0] d);
      bit exp_done;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      s_valid = 1; s_data = d;
      chk("s_ready", s_ready, model_busy);
      @(negedge clk);
      s_valid = 0;
      if (model_busy) begin
         if (n < 16) begin
            pend[n] = d; n++; sum ^= d;
         end else begin
            model_busy = 0;
            exp_done = (d == sum);
            if (exp_done) commit();
            else model_err = 1;
            chk("cfg_done", cfg_done, exp_done);
            chk("tbl_valid_commit", tbl_valid, model_valid);
            chk("cfg_err", cfg_err, model_err);
            @(negedge clk);
            chk("cfg_done_width", cfg_done, 0);
         end
      end
      chk("cfg_busy", cfg_busy, model_busy);
   endtask

   task automatic lookup(input logic [5:0] a, input bit req);
      @(negedge clk);
      in_valid = req; M0 = a;
      @(negedge clk);
      in_valid = 0;
      if (req && model_valid) model_m1 = model_tbl[a];
      chk("out_valid", out_valid, req && model_valid);
      chk("M1", M1, model_m1);
   endtask

   task automatic load_words(input logic [7:0] ck);
      for (int k = 0; k < 16; k++) send(words[k]);
      send(ck);
   endtask

   task automatic rand_lookups(input int cnt);
      for (int i = 0; i < cnt; i++) lookup(6'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
   endtask

   initial begin
      logic [7:0] x;
      rst = 1; cfg_start = 0; s_valid = 0; s_data = 8'h00; in_valid = 0; M0 = 6'h00;
      model_valid = 0; model_busy = 0; model_err = 0; model_m1 = 2'b00; n = 0; sum = 8'h00;
      #12;
      chk("rst_tbl_valid", tbl_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_M1", M1, 0);
      @(negedge clk); rst = 0;

      // 1: lookups ignored without a table, stray words ignored
      lookup(6'h0D, 1);
      send(8'h55);
      chk("idle_tbl_valid", tbl_valid, 0);

      // 2: constant pattern, zero checksum
      for (int k = 0; k < 16; k++) words[k] = 8'hE4;
      start(0);
      load_words(8'h00);
      for (int a = 0; a < 4; a++) lookup(6'(a), 1);
      lookup(6'h3F, 1);
      chk("t2_M1_3F", M1, 2'd3);
      send(8'h12);
      chk("extra_word_tbl_valid", tbl_valid, 1);

      // 3: row-distinct pattern
      x = 8'h00;
      for (int k = 0; k < 16; k++) begin words[k] = 8'(k * 17); x ^= words[k]; end
      start(0);
      load_words(x);
      lookup(6'h24, 1);
      chk("t3_M1_24", M1, 2'b01);
      rand_lookups(12);

      // 4: bad checksum
      start(0);
      load_words(8'hFF);
      lookup(6'h24, 1);
      start(0);
      chk("t4_err_cleared", cfg_err, 0);

      // 5: restart mid-load with a word on the same cycle as cfg_start
      for (int k = 0; k < 7; k++) send(8'($urandom));
      start(1);
      x = 8'h00;
      for (int k = 0; k < 16; k++) begin words[k] = 8'($urandom); x ^= words[k]; end
      load_words(x);
      rand_lookups(24);

      // 6: reset mid-load
      start(0);
      for (int k = 0; k < 10; k++) send(8'($urandom));
      @(negedge clk);
      rst = 1;
      #1;
      model_busy = 0; model_valid = 0; model_err = 0; model_m1 = 2'b00;
      chk("arst_tbl_valid", tbl_valid, 0);
      chk("arst_busy", cfg_busy, 0);
      chk("arst_s_ready", s_ready, 0);
      chk("arst_err", cfg_err, 0);
      chk("arst_M1", M1, 0);
      chk("arst_out_valid", out_valid, 0);
      @(negedge clk); rst = 0;
      rand_lookups(6);
      x = 8'h00;
      for (int k = 0; k < 16; k++) begin words[k] = 8'($urandom); x ^= words[k]; end
      start(0);
      load_words(x);
      rand_lookups(24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/neuron_lut_loader.md
Name: neuron_lut_loader

Overview:
Runtime writer for one LogicNets neuron truth table. Receives a byte stream from the configuration path, unpacks it into 2^IN_BITS entries of OUT_BITS each, verifies an XOR checksum, and commits the table to distributed RAM. It then serves registered lookups (M0 -> M1) with the same input/output bit packing as the fixed-ROM neurons. This allows a layer neuron to be retrained and reloaded without re-synthesis.

Parameters:
IN_BITS, 6, neuron input width; the table holds 2^IN_BITS entries (64).
OUT_BITS, 2, width of each entry; must divide DATA_W.
DATA_W, 8, config stream width; entries per word EPW = DATA_W/OUT_BITS (4), words per table NW = 2^IN_BITS/EPW (16).

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_start  in  1  one-cycle pulse; begins or restarts a table load
s_data  in  DATA_W  config word
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts s_data
cfg_busy  out  1  load in progress
cfg_done  out  1  one-cycle pulse; table committed
cfg_err  out  1  checksum mismatch; sticky until next cfg_start
tbl_valid  out  1  table usable for lookups
in_valid  in  1  lookup request
M0  in  IN_BITS  lookup address (neuron input vector)
out_valid  out  1  M1 valid
M1  out  OUT_BITS  looked-up entry (neuron output)

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; s_ready, cfg_busy, cfg_done, cfg_err, tbl_valid, out_valid = 0; M1 = 0; word counter = 0; checksum = 0. Table RAM contents are not reset.
- States: IDLE -> LOAD on cfg_start. LOAD -> CHECK after word NW-1 is accepted. CHECK -> IDLE once the checksum word is accepted.
- A word transfers when s_valid && s_ready. s_ready = 1 in LOAD and CHECK, 0 in IDLE.
- cfg_start in any state: tbl_valid <= 0, cfg_err <= 0, counter <= 0, checksum <= 0, state <= LOAD. If s_valid is high in the same cycle, that word is ignored (not accepted).
- LOAD, word k accepted: entry EPW*k+j <= s_data[OUT_BITS*j +: OUT_BITS] for j = 0..EPW-1. This fills EPW RAM entries in one cycle; the RAM is organised as NW rows of DATA_W. checksum <= checksum ^ s_data; counter increments.
- CHECK, word accepted:
  - If it equals the checksum: tbl_valid <= 1 and cfg_done pulses for 1 cycle.
  - Otherwise: cfg_err <= 1 and tbl_valid stays 0.
  - In both cases the next state is IDLE.
- cfg_busy = 1 in LOAD and CHECK.
- Lookup: latency 1.
  - When in_valid && tbl_valid, next cycle out_valid = 1 and M1 = entry[M0].
  - Otherwise out_valid = 0 and M1 holds its last value.
  - Lookups are ignored whenever tbl_valid = 0, including during a load.
- Entry index = M0 as an unsigned value. Row = M0[IN_BITS-1:log2(EPW)]; lane = M0[log2(EPW)-1:0].
- rst during LOAD/CHECK aborts the load. tbl_valid = 0 afterwards; the partial table is never usable.
- s_valid with no preceding cfg_start, or extra words after CHECK: ignored. No state change, s_ready = 0.
- Back-pressure: none. The loader never stalls inside LOAD/CHECK; the source may insert idle cycles freely.

Test Plan:
1. Reset, then in_valid=1, M0=6'h0D -> out_valid stays 0; tbl_valid=0; s_ready=0.
2. cfg_start, then 16 words 8'hE4 with gaps, then checksum 8'h00 -> cfg_done pulses once; tbl_valid=1.
   - Lookups M0=0,1,2,3 -> M1=0,1,2,3.
   - M0=6'h3F -> M1=3.
   - Every lookup arrives 1 cycle after its request.
3. Load words k=0..15 = {k[3:0],k[3:0]}, then checksum = XOR of those words -> tbl_valid=1.
   - M0=6'h24 (row 9, lane 0) -> M1 = 9 & 3 = 2'b01.
4. Same words as (3) but checksum 8'hFF -> cfg_err=1, tbl_valid=0, no cfg_done.
   - Next cfg_start clears cfg_err.
5. cfg_start after 7 words, with s_valid high the same cycle -> that word is not accepted; counter restarts at 0.
   - Full reload succeeds; table reflects only the second load.
6. Assert rst after 10 words -> all outputs 0 asynchronously; subsequent lookups are ignored until a complete load with a valid checksum.
